// File: rtl/lipsi_ctrl_pkg.sv
// Shared definitions for the Lipsi accumulator sequencer: state encoding,
// branch condition codes, reset defaults and the decoded-instruction record.
package lipsi_ctrl_pkg;

    localparam logic [7:0] RESET_PC_DEFAULT = 8'h10;
    localparam logic [7:0] REG_BASE_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        OPND   = 3'd3,
        EXEC   = 3'd4,
        BRANCH = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [1:0] CC_ALWAYS  = 2'b00;
    localparam logic [1:0] CC_ZERO    = 2'b01;
    localparam logic [1:0] CC_NONZERO = 2'b10;
    localparam logic [1:0] CC_NEVER   = 2'b11;

    typedef struct packed {
        logic       is_alu;
        logic       is_st;
        logic       is_alui;
        logic       is_br;
        logic       is_exit;
        logic       is_illegal;
        logic [2:0] fn;
        logic [3:0] r;
        logic [1:0] cc;
    } decode_t;

    // Resolve a branch condition code against the accumulator zero flag.
    function automatic logic branch_taken(input logic [1:0] cc, input logic zero);
        logic taken;
        case (cc)
            CC_ALWAYS:  taken = 1'b1;
            CC_ZERO:    taken = zero;
            CC_NONZERO: taken = ~zero;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/lipsi_ctrl_decode.sv
// Combinational instruction-byte classifier for the Lipsi sequencer.
// The ALU function field is pre-selected: bits [6:4] for register ALU ops,
// bits [2:0] for the immediate form.
module lipsi_decode
    import lipsi_ctrl_pkg::*;
(
    input  logic [7:0] instr,
    output decode_t    dec
);

    // Classify the byte into exactly one instruction class; anything unmatched is illegal.
    always_comb begin
        dec    = '0;
        dec.fn = instr[7] ? instr[2:0] : instr[6:4];
        dec.r  = instr[3:0];
        dec.cc = instr[1:0];
        if (!instr[7]) begin
            dec.is_alu = 1'b1;
        end else if (instr[7:4] == 4'b1000) begin
            dec.is_st = 1'b1;
        end else if (instr[7:3] == 5'b11000) begin
            dec.is_alui = 1'b1;
        end else if (instr[7:2] == 6'b110100) begin
            dec.is_br = 1'b1;
        end else if (instr == 8'hFF) begin
            dec.is_exit = 1'b1;
        end else begin
            dec.is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/lipsi_ctrl.sv
// Lipsi sequencer: fetches from a unified synchronous 256-byte memory, decodes
// and steps the accumulator datapath. One decoder is shared: it looks at the
// incoming memory byte during DECODE and at the latched ir in every other state,
// so mem_rdata only reaches the outputs in the DECODE cycle.
module lipsi_ctrl
    import lipsi_ctrl_pkg::*;
#(
    parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [7:0] REG_BASE = REG_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] mem_rdata,
    input  logic       acc_zero,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic       acc_en,
    output logic [2:0] alu_fn,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    state_t     state;
    logic [7:0] ir;
    logic [7:0] dec_in;
    decode_t    dec;
    logic       taken;
    logic [7:0] reg_addr;

    assign dec_in   = (state == DECODE) ? mem_rdata : ir;
    assign taken    = branch_taken(dec.cc, acc_zero);
    assign reg_addr = REG_BASE + {4'h0, dec.r};

    lipsi_decode u_decode (
        .instr (dec_in),
        .dec   (dec)
    );

    // Sequencer state, program counter and instruction register; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FETCH;
                end
                FETCH: begin
                    pc    <= pc + 8'd1;
                    state <= DECODE;
                end
                DECODE: begin
                    ir <= mem_rdata;
                    if (dec.is_alu) begin
                        state <= EXEC;
                    end else if (dec.is_st) begin
                        state <= FETCH;
                    end else if (dec.is_alui) begin
                        pc    <= pc + 8'd1;
                        state <= EXEC;
                    end else if (dec.is_br) begin
                        pc    <= pc + 8'd1;
                        state <= BRANCH;
                    end else if (dec.is_exit) begin
                        state <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end
                EXEC: begin
                    state <= FETCH;
                end
                BRANCH: begin
                    if (taken) pc <= mem_rdata;
                    state <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode from state and ir; write and load strobes are suppressed while reset is low.
    always_comb begin
        mem_addr = pc;
        mem_we   = 1'b0;
        acc_en   = 1'b0;
        alu_fn   = 3'd0;
        busy     = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state)
            FETCH: begin
                busy = 1'b1;
            end
            DECODE: begin
                busy    = 1'b1;
                illegal = dec.is_illegal;
                if (dec.is_alu || dec.is_st) mem_addr = reg_addr;
                mem_we  = reset & dec.is_st;
            end
            EXEC: begin
                busy   = 1'b1;
                acc_en = reset;
                alu_fn = dec.fn;
            end
            BRANCH: begin
                busy = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lipsi_ctrl.sv
// Bench for lipsi_ctrl: a synchronous RAM and accumulator around the sequencer,
// an instruction-level reference model that expands each instruction into its
// expected per-cycle outputs, directed programs with literal expectations, and
// randomized programs with random start pulses and mid-run resets.
module tb_lipsi_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mem_rdata;
    logic       acc_zero;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic       acc_en;
    logic [2:0] alu_fn;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       illegal;

    always #5 clk = ~clk;

    lipsi_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_rdata (mem_rdata),
        .acc_zero  (acc_zero),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .acc_en    (acc_en),
        .alu_fn    (alu_fn),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Datapath surrounding the sequencer
    logic [7:0] ram   [256];
    logic [7:0] image [256];
    logic [7:0] acc;
    logic [7:0] acc_init;
    logic       load_now;

    function automatic logic [7:0] alu(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        case (fn)
            3'd0: y = a + b;
            3'd1: y = a - b;
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = b;
            3'd6: y = a + 8'd1;
            default: y = ~b;
        endcase
        return y;
    endfunction

    assign acc_zero = (acc == 8'h00);

    always @(posedge clk) begin
        if (load_now) begin
            for (int i = 0; i < 256; i++) ram[i] <= image[i];
            acc <= acc_init;
        end else begin
            if (mem_we) ram[mem_addr] <= acc;
            if (acc_en) acc <= alu(alu_fn, acc, mem_rdata);
        end
        mem_rdata <= ram[mem_addr];
    end

    // Reference model
    typedef struct {
        logic [7:0] addr;
        bit         chk_addr;
        logic [7:0] pcv;
        bit         we;
        bit         aen;
        logic [2:0] fn;
        logic [7:0] opnd;
        bit         ill;
        bit         hlt;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_acc;
    logic [7:0] m_pc = 8'h10;
    int         m_mode = 0;   // 0 idle, 1 running, 2 halted
    int         vectors = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rec(input logic [7:0] addr, input bit chk, input logic [7:0] pcv,
                            input bit we, input bit aen, input logic [2:0] fn,
                            input logic [7:0] opnd, input bit ill, input bit hlt);
        exp_t e;
        e.addr = addr; e.chk_addr = chk; e.pcv = pcv; e.we = we; e.aen = aen;
        e.fn = fn; e.opnd = opnd; e.ill = ill; e.hlt = hlt;
        q.push_back(e);
    endtask

    // Expand the instruction at m_pc into the cycles it occupies, FETCH first.
    task automatic gen_instr();
        logic [7:0] p, p1, b, r;
        bit         tk;
        p  = m_pc;
        p1 = p + 8'd1;
        b  = m_mem[p];
        r  = {4'h0, b[3:0]};
        push_rec(p, 1, p, 0, 0, 3'd0, 8'h00, 0, 0);
        if (b < 8'h80) begin
            push_rec(r, 1, p1, 0, 0, 3'd0, 8'h00, 0, 0);
            push_rec(8'h00, 0, p1, 0, 1, b[6:4], m_mem[r], 0, 0);
            m_pc = p1;
        end else if (b[7:4] == 4'h8) begin
            push_rec(r, 1, p1, 1, 0, 3'd0, 8'h00, 0, 0);
            m_pc = p1;
        end else if (b[7:3] == 5'b11000) begin
            push_rec(p1, 1, p1, 0, 0, 3'd0, 8'h00, 0, 0);
            push_rec(8'h00, 0, p1 + 8'd1, 0, 1, b[2:0], m_mem[p1], 0, 0);
            m_pc = p1 + 8'd1;
        end else if (b[7:2] == 6'b110100) begin
            push_rec(p1, 1, p1, 0, 0, 3'd0, 8'h00, 0, 0);
            push_rec(8'h00, 0, p1 + 8'd1, 0, 0, 3'd0, 8'h00, 0, 0);
            case (b[1:0])
                2'd0: tk = 1;
                2'd1: tk = (m_acc == 8'h00);
                2'd2: tk = (m_acc != 8'h00);
                default: tk = 0;
            endcase
            m_pc = tk ? m_mem[p1] : p1 + 8'd1;
        end else if (b == 8'hFF) begin
            push_rec(8'h00, 0, p1, 0, 0, 3'd0, 8'h00, 0, 1);
            m_pc = p1;
        end else begin
            push_rec(8'h00, 0, p1, 0, 0, 3'd0, 8'h00, 1, 0);
            m_pc = p1;
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model's expectation.
    always @(negedge clk) begin
        exp_t e;
        if (load_now) begin
            for (int i = 0; i < 256; i++) m_mem[i] = image[i];
            m_acc = acc_init;
        end
        if (!reset) begin
            check("reset_acc_en", {7'd0, acc_en}, 8'd0);
            check("reset_mem_we", {7'd0, mem_we}, 8'd0);
            m_mode = 0;
            m_pc   = 8'h10;
            q.delete();
        end else if (m_mode == 0) begin
            check("idle_addr", mem_addr, m_pc);
            check("idle_pc", pc, m_pc);
            check("idle_busy", {7'd0, busy}, 8'd0);
            check("idle_halted", {7'd0, halted}, 8'd0);
            check("idle_strobes", {5'd0, illegal, acc_en, mem_we}, 8'd0);
            if (start) m_mode = 1;
        end else if (m_mode == 2) begin
            check("halt_pc", pc, m_pc);
            check("halt_busy", {7'd0, busy}, 8'd0);
            check("halt_halted", {7'd0, halted}, 8'd1);
            check("halt_strobes", {5'd0, illegal, acc_en, mem_we}, 8'd0);
        end else begin
            if (q.size() == 0) gen_instr();
            e = q.pop_front();
            check("run_pc", pc, e.pcv);
            check("run_busy", {6'd0, busy, halted}, 8'd2);
            check("run_illegal", {7'd0, illegal}, {7'd0, e.ill});
            check("run_mem_we", {7'd0, mem_we}, {7'd0, e.we});
            check("run_acc_en", {7'd0, acc_en}, {7'd0, e.aen});
            if (e.aen) check("run_alu_fn", {5'd0, alu_fn}, {5'd0, e.fn});
            if (e.chk_addr) check("run_addr", mem_addr, e.addr);
            if (e.we) m_mem[e.addr] = m_acc;
            if (e.aen) m_acc = alu(e.fn, m_acc, e.opnd);
            if (e.hlt) m_mode = 2;
        end
    end

    task automatic clear_image();
        for (int i = 0; i < 256; i++) image[i] = (i < 16) ? 8'h00 : 8'hFF;
    endtask

    task automatic apply_reset_load();
        @(posedge clk); #2;
        reset    = 1'b0;
        start    = 1'b0;
        load_now = 1'b1;
        @(posedge clk); #2;
        load_now = 1'b0;
        @(posedge clk); #2;
        reset    = 1'b1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int k;
        k = $urandom_range(0, 99);
        if (k < 40)      return {1'b0, 7'($urandom)};
        else if (k < 55) return {4'h8, 4'($urandom)};
        else if (k < 70) return {5'b11000, 3'($urandom)};
        else if (k < 85) return {6'b110100, 2'($urandom)};
        else if (k < 88) return 8'hFF;
        else             return 8'($urandom);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed programs with literal expectations, then randomized programs.
    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        load_now = 1'b0;
        acc_init = 8'h00;

        // ALUI fn0 imm 5, then EXIT
        clear_image();
        image[8'h10] = 8'hC0; image[8'h11] = 8'h05;
        acc_init = 8'h00;
        apply_reset_load();
        check("t1_reset_pc", pc, 8'h10);
        check("t1_reset_addr", mem_addr, 8'h10);
        start_pulse();
        @(negedge clk); check("t1_fetch_addr", mem_addr, 8'h10);
        @(negedge clk); check("t1_decode_addr", mem_addr, 8'h11);
        @(negedge clk); check("t1_exec_acc_en", {7'd0, acc_en}, 8'd1);
                        check("t1_exec_fn", {5'd0, alu_fn}, 8'd0);
                        check("t1_exec_pc", pc, 8'h12);
        repeat (3) @(negedge clk);
        check("t1_halted", {7'd0, halted}, 8'd1);
        check("t1_acc", acc, 8'h05);

        // ST r3
        clear_image();
        image[8'h10] = 8'h83;
        acc_init = 8'h5A;
        apply_reset_load();
        start_pulse();
        @(negedge clk);
        @(negedge clk); check("t2_st_addr", mem_addr, 8'h03);
                        check("t2_st_we", {7'd0, mem_we}, 8'd1);
        @(negedge clk); check("t2_we_drop", {7'd0, mem_we}, 8'd0);
                        check("t2_next_pc", pc, 8'h11);
                        check("t2_stored", ram[8'h03], 8'h5A);

        // BRZ taken and not taken
        for (int z = 0; z < 2; z++) begin
            clear_image();
            image[8'h10] = 8'hD1; image[8'h11] = 8'h40;
            acc_init = (z == 0) ? 8'h00 : 8'h07;
            apply_reset_load();
            start_pulse();
            repeat (4) @(negedge clk);
            check("t3_branch_pc", pc, (z == 0) ? 8'h40 : 8'h12);
        end

        // illegal byte then EXIT, start ignored in HALT
        clear_image();
        image[8'h10] = 8'hE7;
        acc_init = 8'h01;
        apply_reset_load();
        start_pulse();
        @(negedge clk);
        @(negedge clk); check("t4_illegal", {7'd0, illegal}, 8'd1);
                        check("t4_no_strobe", {6'd0, acc_en, mem_we}, 8'd0);
        @(negedge clk); check("t4_illegal_drop", {7'd0, illegal}, 8'd0);
                        check("t4_pc", pc, 8'h11);
        repeat (2) @(negedge clk);
        check("t4_halted", {7'd0, halted}, 8'd1);
        check("t4_busy", {7'd0, busy}, 8'd0);
        @(posedge clk); #2; start_pulse();
        repeat (3) @(negedge clk);
        check("t4_halt_pc", pc, 8'h12);

        // reset in the EXEC cycle of an ALU instruction
        clear_image();
        image[8'h10] = 8'h05; image[8'h05] = 8'h03;
        acc_init = 8'h02;
        apply_reset_load();
        start_pulse();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2; reset = 1'b0;
        @(negedge clk); check("t5_acc_en_gated", {7'd0, acc_en}, 8'd0);
        @(posedge clk); #2; reset = 1'b1;
        @(negedge clk); check("t5_idle", {7'd0, busy}, 8'd0);
                        check("t5_pc", pc, 8'h10);
                        check("t5_acc", acc, 8'h02);

        // ALUI straddling the top of memory
        clear_image();
        image[8'h10] = 8'hD0; image[8'h11] = 8'hFE;
        image[8'hFE] = 8'hC7; image[8'hFF] = 8'h0F; image[8'h00] = 8'hFF;
        acc_init = 8'h00;
        apply_reset_load();
        start_pulse();
        repeat (4) @(negedge clk); check("t6_fetch_pc", pc, 8'hFE);
        @(negedge clk); check("t6_imm_addr", mem_addr, 8'hFF);
        @(negedge clk); check("t6_wrap_pc", pc, 8'h00);
                        check("t6_fn", {5'd0, alu_fn}, 8'd7);
        @(negedge clk); check("t6_fetch_addr", mem_addr, 8'h00);

        // randomized programs
        for (int p = 0; p < 25; p++) begin
            for (int a = 0; a < 256; a++) image[a] = rand_byte();
            acc_init = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            apply_reset_load();
            for (int c = 0; c < 160; c++) begin
                start = ($urandom_range(0, 4) == 0);
                reset = ($urandom_range(0, 79) != 0);
                @(posedge clk); #2;
            end
            start = 1'b0;
            reset = 1'b1;
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
